// File: rtl/hpm_counter_bank_pkg.sv
// hpm_pkg: shared definitions for the HPM counter bank.
//   hpm_selw(channels) : width of a channel select port, max(1, clog2(channels))
//   HPM_WRAP / HPM_SAT : overflow-mode values for the SAT parameter
// No ports (package).
package hpm_pkg;

  localparam int HPM_WRAP = 0;
  localparam int HPM_SAT  = 1;

  function automatic int hpm_selw(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/hpm_counter_bank_if.sv
// hpm_counter_bank_if: control/status bundle of the HPM counter bank.
//   inc, inhibit, ovf_clr   per-channel controls           (master -> slave)
//   ld, ld_sel, ld_data     single-channel load port        (master -> slave)
//   rd_sel                  read channel select             (master -> slave)
//   rd_data                 registered read data            (slave -> master)
//   ovf, ovf_flags, irq     overflow pulse, sticky flags, interrupt (slave -> master)
interface hpm_counter_bank_if
  import hpm_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int SELW     = hpm_selw(CHANNELS)
);
  logic [CHANNELS-1:0] inc;
  logic [CHANNELS-1:0] inhibit;
  logic                ld;
  logic [SELW-1:0]     ld_sel;
  logic [WIDTH-1:0]    ld_data;
  logic [SELW-1:0]     rd_sel;
  logic [WIDTH-1:0]    rd_data;
  logic [CHANNELS-1:0] ovf;
  logic [CHANNELS-1:0] ovf_clr;
  logic [CHANNELS-1:0] ovf_flags;
  logic                irq;

  modport master (
    output inc, inhibit, ld, ld_sel, ld_data, rd_sel, ovf_clr,
    input  rd_data, ovf, ovf_flags, irq
  );

  modport slave (
    input  inc, inhibit, ld, ld_sel, ld_data, rd_sel, ovf_clr,
    output rd_data, ovf, ovf_flags, irq
  );
endinterface

// File: rtl/hpm_counter_bank_slice.sv
// hpm_counter_slice: one channel of the HPM counter bank.
// Holds the count register, the load > hold > increment priority mux,
// overflow detection, the one-cycle ovf pulse and (optionally) a sticky flag.
// Optional feature: macro HPM_CNT_OVF_IRQ_EN enables the sticky flag register;
// without it ovf_flag is tied 0 and ovf_clr is ignored.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   inc        increment request
//   inhibit    freezes increments (loads still apply)
//   ld_hit     load strobe already decoded for this channel
//   ld_data    load value
//   ovf_clr    sticky-flag clear
//   count      current count
//   ovf        registered overflow-event pulse
//   ovf_flag   sticky overflow flag
module hpm_counter_slice
  import hpm_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SAT   = HPM_WRAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             inhibit,
  input  logic             ld_hit,
  input  logic [WIDTH-1:0] ld_data,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] count,
  output logic             ovf,
  output logic             ovf_flag
);

  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;
  logic             ovf_reg;
  logic             ovf_event;

  // Overflow is only an event when the increment actually wins the priority
  // mux; a load or hold on an all-ones count is not an overflow.
  always_comb begin
    count_next = count_reg;
    ovf_event  = 1'b0;
    if (ld_hit) begin
      count_next = ld_data;
    end else if (inc && !inhibit) begin
      if (count_reg == ALL_ONES) begin
        ovf_event  = 1'b1;
        count_next = (SAT == HPM_SAT) ? ALL_ONES : '0;
      end else begin
        count_next = count_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
      ovf_reg   <= 1'b0;
    end else begin
      count_reg <= count_next;
      ovf_reg   <= ovf_event;
    end
  end

  assign count = count_reg;
  assign ovf   = ovf_reg;

`ifdef HPM_CNT_OVF_IRQ_EN
  logic flag_reg;

  // A new overflow beats a clear arriving in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_reg <= 1'b0;
    end else begin
      flag_reg <= ovf_event | (flag_reg & ~ovf_clr);
    end
  end

  assign ovf_flag = flag_reg;
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = ovf_clr;
  assign ovf_flag       = 1'b0;
`endif

endmodule

// File: rtl/hpm_counter_bank.sv
// hpm_counter_bank: bank of CHANNELS independent hardware performance counters.
// Each channel is an hpm_counter_slice; this level decodes the load select,
// provides the registered read mux and ORs the sticky flags into irq.
// Optional feature: macro HPM_CNT_OVF_IRQ_EN enables sticky overflow flags and
// irq; without it ovf_flags and irq read 0.
// Parameters: WIDTH (2..64), CHANNELS (1..16), SAT (HPM_WRAP / HPM_SAT).
// Ports:
//   clk   clock (rising edge)
//   rst   asynchronous active-high reset
//   bus   hpm_counter_bank_if.slave: inc, inhibit, ld, ld_sel, ld_data, rd_sel,
//         ovf_clr in; rd_data, ovf, ovf_flags, irq out
module hpm_counter_bank
  import hpm_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int SAT      = HPM_WRAP
) (
  input  logic               clk,
  input  logic               rst,
  hpm_counter_bank_if.slave  bus
);

  localparam int SELW = hpm_selw(CHANNELS);

  logic [WIDTH-1:0]    count_arr [CHANNELS];
  logic [CHANNELS-1:0] ovf_vec;
  logic [CHANNELS-1:0] flag_vec;
  logic [WIDTH-1:0]    rd_mux;
  logic [WIDTH-1:0]    rd_data_reg;

  // An ld_sel of CHANNELS or more matches no slice, so such loads fall away.
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_slice
    logic ld_hit;
    assign ld_hit = bus.ld && (bus.ld_sel == SELW'(gi));

    hpm_counter_slice #(
      .WIDTH (WIDTH),
      .SAT   (SAT)
    ) u_slice (
      .clk      (clk),
      .rst      (rst),
      .inc      (bus.inc[gi]),
      .inhibit  (bus.inhibit[gi]),
      .ld_hit   (ld_hit),
      .ld_data  (bus.ld_data),
      .ovf_clr  (bus.ovf_clr[gi]),
      .count    (count_arr[gi]),
      .ovf      (ovf_vec[gi]),
      .ovf_flag (flag_vec[gi])
    );
  end

  // Out-of-range selects find no match and return zero.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (bus.rd_sel == SELW'(i)) begin
        rd_mux = count_arr[i];
      end
    end
  end

  // Read samples the pre-update count, giving one cycle of latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_reg <= '0;
    end else begin
      rd_data_reg <= rd_mux;
    end
  end

  assign bus.rd_data   = rd_data_reg;
  assign bus.ovf       = ovf_vec;
  assign bus.ovf_flags = flag_vec;
  assign bus.irq       = |flag_vec;

endmodule

// File: tb/tb_hpm_counter_bank.sv
// Testbench for hpm_counter_bank. Three instances (8-bit): dut 0 = 4 ch wrap,
// dut 1 = 4 ch saturate, dut 2 = 3 ch wrap. A behavioural model computes the
// expected outputs for each clock; they are queued when the stimulus is driven
// and compared when the DUT has produced them. Honours HPM_CNT_OVF_IRQ_EN.
module tb_hpm_counter_bank;

  logic clk;
  logic rst;

  logic [3:0] inc_s  [3];
  logic [3:0] inh_s  [3];
  logic [3:0] clr_s  [3];
  logic       ld_s   [3];
  logic [1:0] lsel_s [3];
  logic [7:0] ldat_s [3];
  logic [1:0] rsel_s [3];

  logic [7:0] rd_o  [3];
  logic [3:0] ovf_o [3];
  logic [3:0] flg_o [3];
  logic       irq_o [3];

  hpm_counter_bank_if #(.WIDTH(8), .CHANNELS(4)) ba ();
  hpm_counter_bank_if #(.WIDTH(8), .CHANNELS(4)) bs ();
  hpm_counter_bank_if #(.WIDTH(8), .CHANNELS(3)) bc ();

  hpm_counter_bank #(.WIDTH(8), .CHANNELS(4), .SAT(0)) dut_a (.clk(clk), .rst(rst), .bus(ba));
  hpm_counter_bank #(.WIDTH(8), .CHANNELS(4), .SAT(1)) dut_s (.clk(clk), .rst(rst), .bus(bs));
  hpm_counter_bank #(.WIDTH(8), .CHANNELS(3), .SAT(0)) dut_c (.clk(clk), .rst(rst), .bus(bc));

  assign ba.inc = inc_s[0];   assign bs.inc = inc_s[1];   assign bc.inc = inc_s[2][2:0];
  assign ba.inhibit = inh_s[0]; assign bs.inhibit = inh_s[1]; assign bc.inhibit = inh_s[2][2:0];
  assign ba.ovf_clr = clr_s[0]; assign bs.ovf_clr = clr_s[1]; assign bc.ovf_clr = clr_s[2][2:0];
  assign ba.ld = ld_s[0];     assign bs.ld = ld_s[1];     assign bc.ld = ld_s[2];
  assign ba.ld_sel = lsel_s[0]; assign bs.ld_sel = lsel_s[1]; assign bc.ld_sel = lsel_s[2];
  assign ba.ld_data = ldat_s[0]; assign bs.ld_data = ldat_s[1]; assign bc.ld_data = ldat_s[2];
  assign ba.rd_sel = rsel_s[0]; assign bs.rd_sel = rsel_s[1]; assign bc.rd_sel = rsel_s[2];

  assign rd_o[0] = ba.rd_data;  assign rd_o[1] = bs.rd_data;  assign rd_o[2] = bc.rd_data;
  assign ovf_o[0] = ba.ovf;     assign ovf_o[1] = bs.ovf;     assign ovf_o[2] = {1'b0, bc.ovf};
  assign flg_o[0] = ba.ovf_flags; assign flg_o[1] = bs.ovf_flags; assign flg_o[2] = {1'b0, bc.ovf_flags};
  assign irq_o[0] = ba.irq;     assign irq_o[1] = bs.irq;     assign irq_o[2] = bc.irq;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int         d;
    logic [7:0] rd;
    logic [3:0] ovf;
    logic [3:0] flg;
    logic       irq;
  } exp_t;

  exp_t  sbq [$];
  int    total = 0;
  int    bad   = 0;
  string cur_test = "init";

  int         nch [3] = '{4, 4, 3};
  int         sat [3] = '{0, 1, 0};
  logic [7:0] mcnt  [3][4];
  logic [3:0] mflag [3];

  task automatic clear_inputs();
    for (int d = 0; d < 3; d++) begin
      inc_s[d] = '0; inh_s[d] = '0; clr_s[d] = '0; ld_s[d] = 1'b0;
      lsel_s[d] = '0; ldat_s[d] = '0; rsel_s[d] = '0;
    end
  endtask

  task automatic model_clear();
    for (int d = 0; d < 3; d++) begin
      mflag[d] = '0;
      for (int i = 0; i < 4; i++) mcnt[d][i] = 8'h00;
    end
    sbq.delete();
  endtask

  // Called just after a falling edge with inputs set: queue the model's view
  // of the coming rising edge, then compare at the next falling edge.
  task automatic tick();
    exp_t e;
    for (int d = 0; d < 3; d++) begin
      e.d   = d;
      e.rd  = (int'(rsel_s[d]) < nch[d]) ? mcnt[d][rsel_s[d]] : 8'h00;
      e.ovf = '0;
      for (int i = 0; i < nch[d]; i++) begin
        if (ld_s[d] && int'(lsel_s[d]) == i) begin
          mcnt[d][i] = ldat_s[d];
        end else if (inc_s[d][i] && !inh_s[d][i]) begin
          if (mcnt[d][i] == 8'hFF) begin
            e.ovf[i]   = 1'b1;
            mcnt[d][i] = (sat[d] == 1) ? 8'hFF : 8'h00;
          end else begin
            mcnt[d][i] = mcnt[d][i] + 8'h01;
          end
        end
`ifdef HPM_CNT_OVF_IRQ_EN
        mflag[d][i] = e.ovf[i] | (mflag[d][i] & ~clr_s[d][i]);
`endif
      end
      e.flg = mflag[d];
      e.irq = |mflag[d];
      sbq.push_back(e);
    end
    @(negedge clk);
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      total++;
      if (rd_o[e.d] !== e.rd) begin
        bad++;
        $display("FAIL %s dut%0d rd_data got=%h want=%h", cur_test, e.d, rd_o[e.d], e.rd);
      end
      total++;
      if (ovf_o[e.d] !== e.ovf) begin
        bad++;
        $display("FAIL %s dut%0d ovf got=%b want=%b", cur_test, e.d, ovf_o[e.d], e.ovf);
      end
      total++;
      if (flg_o[e.d] !== e.flg) begin
        bad++;
        $display("FAIL %s dut%0d ovf_flags got=%b want=%b", cur_test, e.d, flg_o[e.d], e.flg);
      end
      total++;
      if (irq_o[e.d] !== e.irq) begin
        bad++;
        $display("FAIL %s dut%0d irq got=%b want=%b", cur_test, e.d, irq_o[e.d], e.irq);
      end
    end
    $display("[%s] t=%0t rd=%h/%h/%h ovf=%b/%b/%b flags=%b/%b/%b", cur_test, $time,
             rd_o[0], rd_o[1], rd_o[2], ovf_o[0], ovf_o[1], ovf_o[2],
             flg_o[0], flg_o[1], flg_o[2]);
  endtask

  task automatic test_reset();
    cur_test = "reset";
    #1 rst = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      total++;
      if (rd_o[d] !== 8'h00 || ovf_o[d] !== 4'h0 || flg_o[d] !== 4'h0 || irq_o[d] !== 1'b0) begin
        bad++;
        $display("FAIL reset_state dut%0d rd=%h ovf=%b flags=%b irq=%b want all 0",
                 d, rd_o[d], ovf_o[d], flg_o[d], irq_o[d]);
      end
    end
    // Busy inputs while reset is held must be ignored.
    for (int d = 0; d < 3; d++) begin
      inc_s[d] = 4'hF; ld_s[d] = 1'b1; ldat_s[d] = 8'hAA; lsel_s[d] = 2'd0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      total++;
      if (rd_o[d] !== 8'h00 || ovf_o[d] !== 4'h0 || flg_o[d] !== 4'h0) begin
        bad++;
        $display("FAIL reset_hold dut%0d rd=%h ovf=%b flags=%b want all 0",
                 d, rd_o[d], ovf_o[d], flg_o[d]);
      end
    end
    @(negedge clk);
    clear_inputs();
    model_clear();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_wrap();
    cur_test = "wrap";
    ld_s[0] = 1'b1; lsel_s[0] = 2'd1; ldat_s[0] = 8'hFE; rsel_s[0] = 2'd1;
    tick();
    ld_s[0] = 1'b0; inc_s[0] = 4'b0010;
    repeat (3) tick();
    inc_s[0] = '0;
    repeat (2) tick();
  endtask

  task automatic test_sat();
    cur_test = "sat";
    ld_s[1] = 1'b1; lsel_s[1] = 2'd0; ldat_s[1] = 8'hFE; rsel_s[1] = 2'd0;
    tick();
    ld_s[1] = 1'b0; inc_s[1] = 4'b0001;
    repeat (4) tick();
    inc_s[1] = '0;
    repeat (2) tick();
  endtask

  task automatic test_load_priority();
    cur_test = "load_priority";
    ld_s[0] = 1'b1; lsel_s[0] = 2'd0; ldat_s[0] = 8'h11; tick();
    lsel_s[0] = 2'd3; ldat_s[0] = 8'h33; tick();
    lsel_s[0] = 2'd2; ldat_s[0] = 8'h55; inc_s[0] = 4'b0100; inh_s[0] = 4'b0100;
    tick();
    clear_inputs();
    for (int s = 0; s < 4; s++) begin
      rsel_s[0] = 2'(s);
      tick();
    end
    tick();
  endtask

  task automatic test_inhibit();
    cur_test = "inhibit_concurrent";
    inc_s[0] = 4'hF; inh_s[0] = 4'b1010;
    inc_s[2] = 4'b0111;
    for (int s = 0; s < 4; s++) begin
      rsel_s[0] = 2'(s);
      rsel_s[2] = 2'(s % 3);
      tick();
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_flags();
    cur_test = "flags";
    ld_s[0] = 1'b1; lsel_s[0] = 2'd0; ldat_s[0] = 8'hFF; tick();
    ld_s[0] = 1'b0; inc_s[0] = 4'b0001; clr_s[0] = 4'b0001; tick();
    inc_s[0] = '0; tick();
    clr_s[0] = '0; tick();
  endtask

  task automatic test_bounds();
    cur_test = "bounds";
    ld_s[2] = 1'b1;
    for (int s = 0; s < 3; s++) begin
      lsel_s[2] = 2'(s);
      ldat_s[2] = 8'(16 * (s + 1));
      tick();
    end
    lsel_s[2] = 2'd3; ldat_s[2] = 8'h77; tick();
    ld_s[2] = 1'b0;
    for (int s = 0; s < 4; s++) begin
      rsel_s[2] = 2'(s);
      tick();
    end
    tick();
  endtask

  task automatic test_async_reset();
    cur_test = "async_reset";
    ld_s[0] = 1'b1; lsel_s[0] = 2'd3; ldat_s[0] = 8'h00; rsel_s[0] = 2'd3;
    ld_s[1] = 1'b1; lsel_s[1] = 2'd0; ldat_s[1] = 8'hFF; rsel_s[1] = 2'd0;
    tick();
    ld_s[0] = 1'b0; inc_s[0] = 4'b1000;
    ld_s[1] = 1'b0; inc_s[1] = 4'b0001;
    repeat (10) tick();
    #3 rst = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      total++;
      if (rd_o[d] !== 8'h00 || ovf_o[d] !== 4'h0 || flg_o[d] !== 4'h0 || irq_o[d] !== 1'b0) begin
        bad++;
        $display("FAIL async_reset dut%0d rd=%h ovf=%b flags=%b irq=%b want all 0",
                 d, rd_o[d], ovf_o[d], flg_o[d], irq_o[d]);
      end
    end
    @(negedge clk);
    clear_inputs();
    model_clear();
    rst = 1'b0;
    for (int s = 0; s < 4; s++) begin
      rsel_s[0] = 2'(s);
      tick();
    end
    tick();
  endtask

  initial begin
    rst = 1'b0;
    clear_inputs();
    model_clear();
    test_reset();
    test_wrap();
    test_sat();
    test_load_priority();
    test_inhibit();
    test_flags();
    test_bounds();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hpm_counter_bank.md
HPM_COUNTER_BANK -- requirements
Module: hpm_counter_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 32, counter width in bits (range 2..64).
REQ-002 SHALL have parameter CHANNELS, default 4, number of independent counters (range 1..16).
REQ-003 SHALL have parameter SAT, default 0; 0 means wrap at all-ones, 1 means saturate at all-ones.
REQ-004 SHALL derive SELW = max(1, clog2(CHANNELS)) for select ports.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 inc  in  CHANNELS  per-channel increment request, bit i for channel i.
REQ-008 inhibit  in  CHANNELS  per-channel freeze; blocks increment only.
REQ-009 ld  in  1  load strobe.
REQ-010 ld_sel  in  SELW  channel targeted by ld.
REQ-011 ld_data  in  WIDTH  value written on load.
REQ-012 rd_sel  in  SELW  channel to read.
REQ-013 rd_data  out  WIDTH  registered read data.
REQ-014 ovf  out  CHANNELS  one-cycle registered overflow-event pulse per channel.
REQ-015 ovf_clr  in  CHANNELS  per-channel sticky-flag clear.
REQ-016 ovf_flags  out  CHANNELS  sticky overflow flags.
REQ-017 irq  out  1  OR of ovf_flags.

Function
REQ-018 Per-channel next-state priority SHALL be: load (ld and ld_sel==i) > hold (inhibit[i] or !inc[i]) > increment by 1.
REQ-019 Load SHALL take effect on an inhibited channel; a load in the same cycle as inc SHALL discard the increment.
REQ-020 An ld_sel value >= CHANNELS SHALL be ignored, with no channel changed.
REQ-021 Overflow event for channel i SHALL be: increment selected by REQ-018 while count == all-ones.
REQ-022 With SAT=0, an overflow event SHALL produce count 0; with SAT=1, count SHALL stay all-ones.
REQ-023 ovf[i] SHALL be high for exactly the cycle after an overflow event and SHALL repeat on every event (SAT=1 with inc held means high every cycle).
REQ-024 rd_data SHALL present, one cycle after rd_sel is sampled, the count of channel rd_sel as it was before that edge's update; read latency is one cycle.
REQ-025 rd_sel >= CHANNELS SHALL return rd_data = 0.
REQ-026 All channels SHALL update concurrently and independently in the same cycle.

Reset
REQ-027 On rst assertion, all counts, rd_data, ovf, and ovf_flags SHALL go to 0 immediately, independent of clk.
REQ-028 During rst, all inputs SHALL be ignored; the first update SHALL occur on the first rising edge with rst low.
REQ-029 Reset asserted mid-count or mid-load SHALL discard the in-flight update and pending ovf pulse.

Configuration
REQ-030 Macro HPM_CNT_OVF_IRQ_EN SHALL gate the sticky-flag logic.
REQ-031 With the macro defined, ovf_flags[i] SHALL set on overflow event and clear on ovf_clr[i]; a set SHALL win over a simultaneous clear; irq SHALL be |ovf_flags.
REQ-032 With the macro undefined, ports SHALL remain present, ovf_flags and irq SHALL be tied 0, ovf_clr SHALL be ignored, and no flag registers SHALL be inferred.

Structure
REQ-033 Shared package hpm_pkg SHALL hold the SELW computation function and the overflow-mode constants (HPM_WRAP=0, HPM_SAT=1).
REQ-034 One sub-module hpm_counter_slice (single channel: count register, priority mux, overflow detect, ovf pulse, optional flag) SHALL be instantiated CHANNELS times; the read mux and irq OR SHALL live in the top module.

Verification
REQ-035 WIDTH=8, SAT=0: load ch1=0xFE, inc[1] held 3 cycles -> count 0xFF, 0x00, 0x01; ovf[1] high only the cycle after 0xFF->0x00.
REQ-036 WIDTH=8, SAT=1: load ch0=0xFE, inc held 4 cycles -> count 0xFF then stays 0xFF; ovf[0] high on the cycles after each of the last 3 increments.
REQ-037 ld with ld_sel=2, ld_data=0x55, inc[2]=1, inhibit[2]=1 in the same cycle -> ch2=0x55 next cycle; ch0, ch1, and ch3 unaffected.
REQ-038 Count ch3 to 10, pulse rst asynchronously between edges -> rd_data, all counts, and ovf_flags read 0 before the next edge.
REQ-039 Macro defined: overflow on ch0 with ovf_clr[0] the same cycle -> flag set and irq=1; ovf_clr[0] alone next cycle -> flag 0, irq 0.
REQ-040 CHANNELS=3: rd_sel=3 -> rd_data=0; ld_sel=3 -> no counter changes.
